// File: rtl/frame_update_sched_if.sv
// frame_update_sched_if: raster counters, update handshake and display outputs of the frame scheduler
interface frame_update_sched_if;
    logic [11:0] HCNT;
    logic [10:0] VCNT;
    logic        upd_req;
    logic        upd_done;
    logic        HSYNC;
    logic        VSYNC;
    logic        DE;
    logic [10:0] PIX_X;
    logic [10:0] PIX_Y;
    logic        upd_grant;
    logic        upd_abort;
    logic        buf_sel;
    logic        frame_tick;

    modport master (
        output HCNT, VCNT, upd_req, upd_done,
        input  HSYNC, VSYNC, DE, PIX_X, PIX_Y, upd_grant, upd_abort, buf_sel, frame_tick
    );

    modport slave (
        input  HCNT, VCNT, upd_req, upd_done,
        output HSYNC, VSYNC, DE, PIX_X, PIX_Y, upd_grant, upd_abort, buf_sel, frame_tick
    );
endinterface

// File: rtl/frame_update_sched.sv
// frame_update_sched: registered 1080p timing outputs plus a vblank-only frame buffer write scheduler
module frame_update_sched #(
    parameter logic [11:0] ACTIVE_H  = 12'd1920,
    parameter logic [11:0] FP_H      = 12'd88,
    parameter logic [11:0] SYNC_H    = 12'd44,
    parameter logic [11:0] TOTAL_H   = 12'd2200,
    parameter logic [11:0] ACTIVE_V  = 12'd1080,
    parameter logic [11:0] FP_V      = 12'd4,
    parameter logic [11:0] SYNC_V    = 12'd5,
    parameter logic [11:0] TOTAL_V   = 12'd1125,
    parameter logic [11:0] MIN_LINES = 12'd8,
    parameter logic        SYNC_POL  = 1'b1
) (
    input logic iCLK,
    input logic reset,
    frame_update_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_VB, GRANT, SWAP_PEND} state_t;

    state_t      state;
    logic [11:0] hc;
    logic [11:0] vc;
    logic [11:0] lines_left;
    logic        in_range;
    logic        hs_act;
    logic        vs_act;
    logic        de_act;
    logic        vblank;
    logic        room;
    logic        vb_start;
    logic        frame_end;

    assign hc         = bus.HCNT;
    assign vc         = {1'b0, bus.VCNT};
    assign in_range   = (hc < TOTAL_H) && (vc < TOTAL_V);
    assign hs_act     = in_range && (hc >= ACTIVE_H + FP_H) && (hc < ACTIVE_H + FP_H + SYNC_H);
    assign vs_act     = in_range && (vc >= ACTIVE_V + FP_V) && (vc < ACTIVE_V + FP_V + SYNC_V);
    assign de_act     = (hc < ACTIVE_H) && (vc < ACTIVE_V);
    assign vblank     = in_range && (vc >= ACTIVE_V);
    assign lines_left = TOTAL_V - vc;
    assign room       = lines_left >= MIN_LINES;
    assign vb_start   = (vc == ACTIVE_V) && (hc == 12'd0);
    assign frame_end  = (hc == TOTAL_H - 12'd1) && (vc == TOTAL_V - 12'd1);

    // Raster outputs: one-clock registered decode of the incoming counters
    always_ff @(posedge iCLK or negedge reset) begin
        if (!reset) begin
            bus.HSYNC      <= ~SYNC_POL;
            bus.VSYNC      <= ~SYNC_POL;
            bus.DE         <= 1'b0;
            bus.PIX_X      <= '0;
            bus.PIX_Y      <= '0;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.HSYNC      <= hs_act ? SYNC_POL : ~SYNC_POL;
            bus.VSYNC      <= vs_act ? SYNC_POL : ~SYNC_POL;
            bus.DE         <= de_act;
            bus.PIX_X      <= de_act ? bus.HCNT[10:0] : '0;
            bus.PIX_Y      <= de_act ? bus.VCNT : '0;
            bus.frame_tick <= (hc == 12'd0) && (vc == 12'd0);
        end
    end

    // Update scheduler: grants only in vblank, swaps buffers at frame end after a completed write
    always_ff @(posedge iCLK or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            bus.upd_grant <= 1'b0;
            bus.upd_abort <= 1'b0;
            bus.buf_sel   <= 1'b0;
        end else begin
            bus.upd_abort <= 1'b0;
            if (in_range) begin
                case (state)
                    IDLE: begin
                        if (bus.upd_req && vblank && room) begin
                            state         <= GRANT;
                            bus.upd_grant <= 1'b1;
                        end else if (bus.upd_req) begin
                            state <= WAIT_VB;
                        end
                    end
                    WAIT_VB: begin
                        if (!bus.upd_req) begin
                            state <= IDLE;
                        end else if (vb_start) begin
                            state         <= GRANT;
                            bus.upd_grant <= 1'b1;
                        end
                    end
                    GRANT: begin
                        if (bus.upd_done) begin
                            bus.upd_grant <= 1'b0;
                            state         <= frame_end ? IDLE : SWAP_PEND;
                            bus.buf_sel   <= frame_end ? ~bus.buf_sel : bus.buf_sel;
                        end else if (frame_end) begin
                            bus.upd_grant <= 1'b0;
                            bus.upd_abort <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                    SWAP_PEND: begin
                        if (frame_end) begin
                            bus.buf_sel <= ~bus.buf_sel;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_frame_update_sched.sv
// tb_frame_update_sched: directed vectors with a queue scoreboard checked by an independent monitor
module tb_frame_update_sched;
    logic iCLK  = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        logic        hs, vs, de;
        logic [10:0] px, py;
        logic        tick, grant, abort, bsel;
    } exp_t;

    exp_t q[$];
    exp_t m;

    frame_update_sched_if bus();

    frame_update_sched dut (
        .iCLK  (iCLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Drive one counter/handshake vector and queue the output expected one clock later
    task automatic step(int h, int v, bit req, bit done, bit g, bit ab, bit b);
        exp_t e;
        bit   inr;
        @(negedge iCLK);
        bus.HCNT     = 12'(h);
        bus.VCNT     = 11'(v);
        bus.upd_req  = req;
        bus.upd_done = done;
        inr     = (h < 2200) && (v < 1125);
        e.hs    = inr && h >= 2008 && h < 2052;
        e.vs    = inr && v >= 1084 && v < 1089;
        e.de    = (h < 1920) && (v < 1080);
        e.px    = e.de ? 11'(h) : 11'd0;
        e.py    = e.de ? 11'(v) : 11'd0;
        e.tick  = (h == 0) && (v == 0);
        e.grant = g;
        e.abort = ab;
        e.bsel  = b;
        q.push_back(e);
    endtask

    // Monitor: compare every registered output against the oldest queued expectation
    always @(posedge iCLK) begin
        #1;
        if (q.size() > 0) begin
            m = q.pop_front();
            chk("hsync", 32'(bus.HSYNC), 32'(m.hs));
            chk("vsync", 32'(bus.VSYNC), 32'(m.vs));
            chk("de", 32'(bus.DE), 32'(m.de));
            chk("pix_x", 32'(bus.PIX_X), 32'(m.px));
            chk("pix_y", 32'(bus.PIX_Y), 32'(m.py));
            chk("frame_tick", 32'(bus.frame_tick), 32'(m.tick));
            chk("upd_grant", 32'(bus.upd_grant), 32'(m.grant));
            chk("upd_abort", 32'(bus.upd_abort), 32'(m.abort));
            chk("buf_sel", 32'(bus.buf_sel), 32'(m.bsel));
        end
    end

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge iCLK);
        #2;
        if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        bus.HCNT = 12'd0; bus.VCNT = 11'd0; bus.upd_req = 1'b0; bus.upd_done = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        chk("rst_hsync", 32'(bus.HSYNC), 32'd0);
        chk("rst_vsync", 32'(bus.VSYNC), 32'd0);
        chk("rst_de", 32'(bus.DE), 32'd0);
        chk("rst_grant", 32'(bus.upd_grant), 32'd0);
        chk("rst_tick", 32'(bus.frame_tick), 32'd0);
        @(negedge iCLK);
        reset = 1'b1;
        // raster decode, including sync/active boundaries and out-of-range counters
        step(0, 0, 0, 0, 0, 0, 0);
        step(1919, 1079, 0, 0, 0, 0, 0);
        step(1920, 0, 0, 0, 0, 0, 0);
        step(2007, 5, 0, 0, 0, 0, 0);
        step(2008, 5, 0, 0, 0, 0, 0);
        step(2051, 5, 0, 0, 0, 0, 0);
        step(2052, 5, 0, 0, 0, 0, 0);
        step(100, 1083, 0, 0, 0, 0, 0);
        step(100, 1084, 0, 0, 0, 0, 0);
        step(2199, 1088, 0, 0, 0, 0, 0);
        step(0, 1089, 0, 0, 0, 0, 0);
        step(3000, 1085, 0, 0, 0, 0, 0);
        step(2010, 2000, 0, 0, 0, 0, 0);
        // request in active video waits for vblank, done then swap at wrap
        step(100, 500, 1, 0, 0, 0, 0);
        step(0, 1079, 1, 0, 0, 0, 0);
        step(0, 1080, 1, 0, 1, 0, 0);
        step(5, 1090, 0, 0, 1, 0, 0);
        step(0, 1100, 0, 1, 0, 0, 0);
        step(10, 1110, 0, 0, 0, 0, 0);
        step(2199, 1124, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        // stray done in idle
        step(50, 50, 0, 1, 0, 0, 1);
        // late request (5 lines left) deferred to next vblank
        step(0, 1120, 1, 0, 0, 0, 1);
        step(2199, 1124, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 1);
        step(0, 1080, 1, 0, 1, 0, 1);
        // grant held without done aborts at wrap
        step(100, 1100, 0, 0, 1, 0, 1);
        step(2199, 1124, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        // 7 lines left waits; out-of-range holds; dropping req returns to idle
        step(0, 1118, 1, 0, 0, 0, 1);
        step(0, 1125, 1, 0, 0, 0, 1);
        step(0, 5, 0, 0, 0, 0, 1);
        step(0, 1090, 1, 0, 1, 0, 1);
        step(2010, 1085, 0, 0, 1, 0, 1);
        drain();
        // asynchronous reset while granted
        reset = 1'b0;
        #1;
        chk("arst_grant", 32'(bus.upd_grant), 32'd0);
        chk("arst_buf_sel", 32'(bus.buf_sel), 32'd0);
        chk("arst_hsync", 32'(bus.HSYNC), 32'd0);
        chk("arst_vsync", 32'(bus.VSYNC), 32'd0);
        chk("arst_abort", 32'(bus.upd_abort), 32'd0);
        @(negedge iCLK);
        reset = 1'b1;
        step(2008, 5, 0, 0, 0, 0, 0);
        step(0, 1090, 0, 0, 0, 0, 0);
        // exactly 8 lines left grants at once; done on the wrap clock swaps without abort
        step(0, 1117, 1, 0, 1, 0, 0);
        step(2199, 1124, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
